// File: rtl/cimg_sensor_sync_if.sv
// cimg_sensor_sync_if: aligned pixel stream from the sensor front-end to the image buffer writer.
interface cimg_sensor_sync_if;
    logic [7:0] sensor_dout;
    logic       frame_begin;
    logic       frame_end;
    logic       frame_state;
    logic       line_begin;
    logic       line_state;
    logic       sensor_state;
    modport master (output sensor_dout, frame_begin, frame_end, frame_state, line_begin, line_state, sensor_state);
    modport slave  (input  sensor_dout, frame_begin, frame_end, frame_state, line_begin, line_state, sensor_state);
endinterface

// File: rtl/cimg_sensor_sync.sv
// cimg_sensor_sync: synchronises raw camera pins, locks onto frame boundaries and emits an aligned pixel stream.
module cimg_sensor_sync #(
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
    parameter bit HREF_ACTIVE_HIGH  = 1'b1,
    parameter int LINE_WIDTH        = 640,
    parameter int CNT_W             = 12
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       sensor_vsync,
    input  logic                       sensor_href,
    input  logic [7:0]                 sensor_data,
    cimg_sensor_sync_if.master         pix,
    output logic [CNT_W-1:0]           frame_lines,
    output logic                       line_err,
    output logic [15:0]                frame_count
);
    typedef enum logic [2:0] {IDLE, WAIT_VS, WAIT_VE, FRAME, VBLANK} state_t;
    state_t state, next;
    logic [1:0] vs_s, hr_s;
    logic [7:0] d1, d2;
    logic vs, hr, hr_q, in_frame, fb, fe, lb, ls_next, l_end;
    logic [CNT_W-1:0] pix_cnt, line_cnt;
    assign vs       = VSYNC_ACTIVE_HIGH ? vs_s[1] : ~vs_s[1];
    assign hr       = HREF_ACTIVE_HIGH ? hr_s[1] : ~hr_s[1];
    assign in_frame = next == FRAME;
    assign fb       = in_frame && state != FRAME;
    assign fe       = !in_frame && state == FRAME;
    assign lb       = in_frame & hr & ~hr_q;
    // A line only starts on an href rising edge, so a line already running at frame entry is dropped
    assign ls_next  = in_frame & hr & (pix.line_state | lb);
    assign l_end    = pix.line_state & ~ls_next;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = enable ? WAIT_VS : IDLE;
            WAIT_VS: next = !enable ? IDLE : vs ? WAIT_VE : WAIT_VS;
            WAIT_VE: next = !enable ? IDLE : !vs ? FRAME : WAIT_VE;
            FRAME:   next = !vs ? FRAME : enable ? VBLANK : IDLE;
            VBLANK:  next = !enable ? IDLE : !vs ? FRAME : VBLANK;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            vs_s <= {2{~VSYNC_ACTIVE_HIGH}};
            hr_s <= {2{~HREF_ACTIVE_HIGH}};
            d1 <= '0;
            d2 <= '0;
            hr_q <= 1'b0;
            pix.sensor_dout <= '0;
            pix.frame_begin <= 1'b0;
            pix.frame_end <= 1'b0;
            pix.frame_state <= 1'b0;
            pix.line_begin <= 1'b0;
            pix.line_state <= 1'b0;
            pix.sensor_state <= 1'b0;
            pix_cnt <= '0;
            line_cnt <= '0;
            frame_lines <= '0;
            line_err <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= next;
            vs_s <= {vs_s[0], sensor_vsync};
            hr_s <= {hr_s[0], sensor_href};
            d1 <= sensor_data;
            d2 <= d1;
            hr_q <= hr;
            pix.sensor_dout <= ls_next ? d2 : 8'd0;
            pix.frame_begin <= fb;
            pix.frame_end <= fe;
            pix.frame_state <= in_frame;
            pix.line_begin <= lb;
            pix.line_state <= ls_next;
            pix.sensor_state <= in_frame || next == VBLANK;
            if (lb)
                pix_cnt <= CNT_W'(1);
            else if (ls_next && !(&pix_cnt))
                pix_cnt <= pix_cnt + CNT_W'(1);
            // hr still high at a line end means vsync cut the line short
            if (fb)
                line_err <= 1'b0;
            else if (l_end && (hr || pix_cnt != CNT_W'(LINE_WIDTH)))
                line_err <= 1'b1;
            if (fb)
                line_cnt <= lb ? CNT_W'(1) : '0;
            else if (lb)
                line_cnt <= line_cnt + CNT_W'(1);
            if (fe) begin
                frame_lines <= line_cnt;
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/cimg_sensor_sync.md
Name: cimg_sensor_sync

Overview:
- Front-end stage of the image capture path; directly upstream of the image buffer write controller.
- Samples raw parallel camera pins (VSYNC, HREF, 8-bit data) in the pixel clock domain and locks onto frame boundaries.
- Emits aligned pixel bytes plus frame_begin / line_begin / frame_state / line_state / sensor_state, the exact timing contract the buffer controller packs into 32-bit words.
- Also reports per-frame geometry and line-length errors for firmware.

Parameters:
- VSYNC_ACTIVE_HIGH, 1, polarity of sensor_vsync (1: high = vertical blanking).
- HREF_ACTIVE_HIGH, 1, polarity of sensor_href (1: high = pixel valid).
- LINE_WIDTH, 640, expected bytes per line; must be a multiple of 4.
- CNT_W, 12, width of pixel and line counters.

Ports:
- clock  in  1  sensor pixel clock; one byte per cycle while HREF is active.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable from register file.
- sensor_vsync  in  1  raw VSYNC pin.
- sensor_href  in  1  raw HREF pin.
- sensor_data  in  8  raw pixel byte.
- sensor_state  out  1  locked to sensor (FRAME or VBLANK state).
- sensor_dout  out  8  pixel byte, aligned to line_begin / line_state.
- frame_begin  out  1  1-cycle pulse at frame start.
- frame_end  out  1  1-cycle pulse at frame end.
- frame_state  out  1  high while in FRAME state.
- line_begin  out  1  1-cycle pulse coincident with first byte of a line.
- line_state  out  1  high for every valid byte of a line, including the first.
- frame_lines  out  CNT_W  line count of the last completed frame.
- line_err  out  1  sticky: a line in the current frame had length != LINE_WIDTH; cleared at frame_begin.
- frame_count  out  16  completed frames since reset; wraps.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Input path:
  - vsync and href pass through 2-FF synchronisers, then are normalised to active-high per the parameters.
  - sensor_data is delayed by the same number of stages.
  - Fixed latency of 3 clocks from pin to sensor_dout / line_state.
- States:
  - IDLE -> WAIT_VS when enable=1.
  - WAIT_VS -> WAIT_VE on vsync active.
  - WAIT_VE -> FRAME on vsync inactive.
  - FRAME -> VBLANK on vsync active.
  - VBLANK -> FRAME on vsync inactive.
  - WAIT_VS or WAIT_VE with enable=0 -> IDLE immediately.
  - FRAME with enable=0: finish the frame; on vsync active go to IDLE and still emit frame_end.
  - VBLANK with enable=0 -> IDLE.
- Lock rule: capture never starts mid-frame; a full vsync active-to-inactive sequence must be seen after enable.
- Frame pulses:
  - frame_begin asserts in the cycle of entry to FRAME.
  - frame_end asserts in the cycle of exit from FRAME.
  - frame_state = (state == FRAME), registered with the state.
- Line timing:
  - line_begin pulses on the synchronised href rising edge, only while in FRAME.
  - line_state = href & FRAME.
  - sensor_dout carries the byte sampled with that href.
  - href already high on entry to FRAME: no line_begin and line_state held 0 until href falls (partial line discarded).
- Pixel counter:
  - Cleared at line_begin, then counts bytes while line_state is high; saturates at all-ones.
  - On href falling in FRAME, count != LINE_WIDTH sets line_err.
- Frame ends while href is high:
  - line_state drops in the same cycle as frame_state.
  - The line counts toward frame_lines and sets line_err.
- frame_lines: line counter incremented per line_begin, cleared at frame_begin, copied to frame_lines at frame_end.
- frame_count increments at frame_end and wraps 0xFFFF -> 0.
- sensor_state = state in {FRAME, VBLANK}.
- sensor_dout is 0 whenever line_state is 0.
- Simultaneous events:
  - vsync and href edges in the same cycle: the vsync transition takes priority.
  - line_begin is never asserted in the cycle frame_begin asserts unless href rises in that same cycle; in that case both assert.

Test Plan:
- Reset then enable=1 mid-frame (vsync inactive, href toggling) -> no frame_begin until vsync goes active then inactive; sensor_state=0 meanwhile.
- 4 lines x 640 bytes, data ramp 0..255 -> 4 line_begin pulses, each with sensor_dout = first ramp byte 3 clocks after pin; line_err=0; frame_lines=4 and frame_count=1 after frame_end.
- One line of 638 bytes -> line_err=1 until the next frame_begin; other lines still pass through unchanged.
- vsync asserted while href high at byte 100 -> frame_state and line_state fall in the same cycle; frame_end pulses once; line_err=1.
- enable deasserted at mid-frame -> current frame completes with frame_end, state goes to IDLE, sensor_state=0; the next frame is ignored.
- VSYNC_ACTIVE_HIGH=0, HREF_ACTIVE_HIGH=0 with inverted stimulus -> output sequence identical to the normal-polarity ramp case.
